// File: rtl/cpu_phase_gen.sv
// rtl/cpu_phase_gen.sv - two-phase non-overlapping clock phases, CPU power-on reset and halt/step control
module cpu_phase_gen #(
  parameter int PHASE_LEN  = 4,
  parameter int POR_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halt_req,
  input  logic step,
  output logic phi1,
  output logic phi2,
  output logic phi1_en,
  output logic phi2_en,
  output logic cpu_rst_n,
  output logic halted
);

  localparam int CW = $clog2(PHASE_LEN + 1);
  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] POR_MAX  = PW'(POR_CYCLES);
  localparam logic [PW-1:0] POR_ONE  = PW'(1);

  typedef enum logic [2:0] {
    P1   = 3'd0,
    G1   = 3'd1,
    P2   = 3'd2,
    G2   = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] por_cnt;

  // Outputs are set on the transition into each state so they are valid during it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= G2;
      cnt       <= '0;
      por_cnt   <= '0;
      phi1      <= 1'b0;
      phi2      <= 1'b0;
      phi1_en   <= 1'b0;
      phi2_en   <= 1'b0;
      cpu_rst_n <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (por_cnt != POR_MAX) por_cnt <= por_cnt + POR_ONE;
      phi1_en <= 1'b0;
      phi2_en <= 1'b0;
      case (state)
        P1: begin
          if (cnt == CNT_LAST) begin
            state <= G1;
            cnt   <= '0;
            phi1  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        G1: begin
          state   <= P2;
          cnt     <= '0;
          phi2    <= 1'b1;
          phi2_en <= 1'b1;
        end
        P2: begin
          if (cnt == CNT_LAST) begin
            state <= G2;
            cnt   <= '0;
            phi2  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        G2: begin
          cnt <= '0;
          // Halting is only honoured once the core is out of reset.
          if (halt_req && cpu_rst_n) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state   <= P1;
            phi1    <= 1'b1;
            phi1_en <= 1'b1;
            if (por_cnt >= POR_MAX) cpu_rst_n <= 1'b1;
          end
        end
        HALT: begin
          cnt <= '0;
          if (!halt_req || step) begin
            state   <= P1;
            halted  <= 1'b0;
            phi1    <= 1'b1;
            phi1_en <= 1'b1;
            if (por_cnt >= POR_MAX) cpu_rst_n <= 1'b1;
          end
        end
        default: begin
          state  <= G2;
          cnt    <= '0;
          phi1   <= 1'b0;
          phi2   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_phase_gen.sv
// tb/tb_cpu_phase_gen.sv - directed self-checking bench for cpu_phase_gen
module tb_cpu_phase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, halt_req, step, halt_req_b, step_b;
  logic phi1, phi2, phi1_en, phi2_en, cpu_rst_n, halted;
  logic phi1_b, phi2_b, phi1_en_b, phi2_en_b, cpu_rst_n_b, halted_b;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int base = 0;
  int p1e = 0;
  int p2e = 0;

  cpu_phase_gen #(.PHASE_LEN(4), .POR_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .step(step),
    .phi1(phi1), .phi2(phi2), .phi1_en(phi1_en), .phi2_en(phi2_en),
    .cpu_rst_n(cpu_rst_n), .halted(halted)
  );

  cpu_phase_gen #(.PHASE_LEN(1), .POR_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req_b), .step(step_b),
    .phi1(phi1_b), .phi2(phi2_b), .phi1_en(phi1_en_b), .phi2_en(phi2_en_b),
    .cpu_rst_n(cpu_rst_n_b), .halted(halted_b)
  );

  function automatic logic [7:0] outs_a();
    return {2'b00, phi1, phi2, phi1_en, phi2_en, cpu_rst_n, halted};
  endfunction

  function automatic logic [7:0] outs_b();
    return {2'b00, phi1_b, phi2_b, phi1_en_b, phi2_en_b, cpu_rst_n_b, halted_b};
  endfunction

  // pos = clk edges since the most recent P1 entry within the bus cycle
  function automatic logic [7:0] exp_vec(input int pos, input int pl, input bit rstn, input bit hlt);
    logic e1, e2, s1, s2;
    if (hlt) return {6'b000000, rstn, 1'b1};
    e1 = (pos < pl);
    e2 = (pos >= pl + 1) && (pos <= 2 * pl);
    s1 = (pos == 0);
    s2 = (pos == pl + 1);
    return {2'b00, e1, e2, s1, s2, rstn, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    chk("overlap_a", {7'b0, phi1 & phi2}, 8'h00);
    chk("overlap_b", {7'b0, phi1_b & phi2_b}, 8'h00);
  endtask

  // Both instances share rst_n; instance b holds halt_req high from power-on.
  task automatic check_b();
    if (k >= 21) chk("s5_halted_b", outs_b(), exp_vec(0, 1, 1'b1, 1'b1));
    else         chk("s5_run_b", outs_b(), exp_vec((k - 1) % 4, 1, k >= 17, 1'b0));
  endtask

  initial begin
    rst_n      = 1'b0;
    halt_req   = 1'b0;
    step       = 1'b0;
    halt_req_b = 1'b1;
    step_b     = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", outs_a(), 8'h00);
    chk("reset_b", outs_b(), 8'h00);
    #2 rst_n = 1'b1;
    k = 0;

    // power-on sequence, stopping mid-P2
    for (int i = 0; i < 27; i++) begin
      tick();
      chk("s1_run", outs_a(), exp_vec((k - 1) % 10, 4, k >= 21, 1'b0));
      check_b();
    end

    // asynchronous reset mid-P2
    #2 rst_n = 1'b0;
    #1;
    chk("s2_async_a", outs_a(), 8'h00);
    chk("s2_async_b", outs_b(), 8'h00);
    @(posedge clk);
    #1;
    chk("s2_held_a", outs_a(), 8'h00);
    #2 rst_n = 1'b1;
    k = 0;

    for (int i = 0; i < 30; i++) begin
      tick();
      chk("s2_rerun", outs_a(), exp_vec((k - 1) % 10, 4, k >= 21, 1'b0));
      check_b();
    end

    // halt requested mid-P1: the cycle completes, HALT after G2
    tick();
    chk("s3_p1", outs_a(), exp_vec(k - 31, 4, 1'b1, 1'b0));
    tick();
    chk("s3_p1", outs_a(), exp_vec(k - 31, 4, 1'b1, 1'b0));
    halt_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s3_finish", outs_a(), exp_vec(k - 31, 4, 1'b1, 1'b0));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_halt", outs_a(), exp_vec(0, 4, 1'b1, 1'b1));
    end
    halt_req = 1'b0;
    tick();
    chk("s3_resume", outs_a(), exp_vec(0, 4, 1'b1, 1'b0));

    // single step while halted
    base = k;
    halt_req = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("s4_to_halt", outs_a(), exp_vec(k - base, 4, 1'b1, 1'b0));
    end
    tick();
    chk("s4_halt", outs_a(), exp_vec(0, 4, 1'b1, 1'b1));
    tick();
    chk("s4_halt", outs_a(), exp_vec(0, 4, 1'b1, 1'b1));
    step = 1'b1;
    base = k + 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      step = 1'b0;
      p1e += int'(phi1_en);
      p2e += int'(phi2_en);
      chk("s4_step", outs_a(), exp_vec(k - base, 4, 1'b1, 1'b0));
    end
    tick();
    chk("s4_rehalt", outs_a(), exp_vec(0, 4, 1'b1, 1'b1));
    chk("s4_phi1_en_count", 8'(p1e), 8'd1);
    chk("s4_phi2_en_count", 8'(p2e), 8'd1);
    tick();
    chk("s4_stay", outs_a(), exp_vec(0, 4, 1'b1, 1'b1));

    // step pulses while running are ignored
    halt_req = 1'b0;
    base = k + 1;
    for (int i = 0; i < 30; i++) begin
      step = (i % 3 == 1);
      tick();
      chk("s6_run", outs_a(), exp_vec((k - base) % 10, 4, 1'b1, 1'b0));
    end
    step = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
